// File: rtl/seq_div_w_if.sv
// rtl/seq_div_w_if.sv - operand/result handshake bundle for the sequential divider
interface seq_div_w_if #(
    parameter int W = 16
);
    logic         load;
    logic         sgn;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ready;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;

    // Controller side: issues operands, observes results
    modport master (
        output load, sgn, x, y,
        input  ready, done, q, r, dbz
    );

    // Divider side
    modport slave (
        input  load, sgn, x, y,
        output ready, done, q, r, dbz
    );
endinterface

// File: rtl/seq_div_w.sv
// rtl/seq_div_w.sv - multi-cycle restoring divider, one quotient bit per clock; SIGNED_DIV_EN enables signed mode
module seq_div_w #(
    parameter int W  = 16,
    parameter int CW = 6
) (
    input logic         clk_i,
    input logic         rst_i,
    seq_div_w_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ZERO
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dq_q, dq_d;     // dividend shifting out, quotient shifting in
    logic [W-1:0]  div_q, div_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  r_q, r_d;
    logic          dbz_q, dbz_d;
    logic          done_q, done_d;
    logic          negq_q, negq_d; // quotient sign correction at done
    logic          negr_q, negr_d; // remainder follows the dividend sign

    logic [W:0]    diff;
    logic [W-1:0]  rem_n, dq_n;
    logic [W-1:0]  mag_x, mag_y;
    logic          sx, sy;

`ifndef SIGNED_DIV_EN
    logic unused_sgn;
    assign unused_sgn = bus.sgn;
`endif

    // Next-state, datapath step and result formation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dq_d    = dq_q;
        div_d   = div_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        negq_d  = negq_q;
        negr_d  = negr_q;

`ifdef SIGNED_DIV_EN
        sx    = bus.sgn & bus.x[W-1];
        sy    = bus.sgn & bus.y[W-1];
        mag_x = sx ? -bus.x : bus.x;
        mag_y = sy ? -bus.y : bus.y;
`else
        sx    = 1'b0;
        sy    = 1'b0;
        mag_x = bus.x;
        mag_y = bus.y;
`endif

        // Trial subtraction of the divisor from the shifted partial remainder
        diff = {rem_q, dq_q[W-1]} - {1'b0, div_q};
        if (diff[W]) begin
            rem_n = {rem_q[W-2:0], dq_q[W-1]};
            dq_n  = {dq_q[W-2:0], 1'b0};
        end else begin
            rem_n = diff[W-1:0];
            dq_n  = {dq_q[W-2:0], 1'b1};
        end

        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    rem_d  = '0;
                    div_d  = mag_y;
                    negq_d = sx ^ sy;
                    negr_d = sx;
                    if (bus.y == '0) begin
                        // Raw dividend kept so the zero-divisor result returns x unchanged
                        dq_d    = bus.x;
                        state_d = S_ZERO;
                    end else begin
                        dq_d    = mag_x;
                        cnt_d   = CW'(W);
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_n;
                dq_d  = dq_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    q_d     = negq_q ? -dq_n : dq_n;
                    r_d     = negr_q ? -rem_n : rem_n;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ZERO: begin
                q_d     = '1;
                r_d     = dq_q;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight division
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            div_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dq_q    <= dq_d;
            div_q   <= div_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.done  = done_q;
    assign bus.q     = q_q;
    assign bus.r     = r_q;
    assign bus.dbz   = dbz_q;
endmodule

// File: doc/seq_div_w.md
Name: seq_div_w

Overview:
- Parametrised, multi-cycle restoring divider. Computes one quotient bit per clock.
- Successor to the single-cycle 16-bit divider block.
- Adds a start/ready/done handshake, a remainder output, divide-by-zero flagging and width parameterisation.
- Sits on the datapath as a shared arithmetic unit. A controller issues operands and waits for the done pulse.

Parameters:
- W, 16, operand/result width in bits (legal range 2..32)
- CW, 6, iteration counter width; must satisfy 2^CW > W

Ports:
- clk  input  1  system clock; all state changes on posedge
- rst  input  1  synchronous active-high reset
- load  input  1  start request; accepted only when ready=1
- sgn  input  1  signed-mode select, sampled with load (only honoured with SIGNED_DIV_EN)
- x  input  W  dividend, sampled on the accepting edge
- y  input  W  divisor, sampled on the accepting edge
- ready  output  1  high when idle and able to accept load
- done  output  1  one-cycle pulse: q/r/dbz valid and updated
- q  output  W  quotient, held until next done
- r  output  W  remainder, held until next done
- dbz  output  1  divide-by-zero flag for the current result, held with q/r

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, ready=1, done=0, q=0, r=0, dbz=0, counter=0, internal regs cleared.
- rst has priority over everything, including mid-operation. An in-flight division is discarded and done does not pulse.
- States:
  - IDLE: ready=1. On posedge with load=1, latch x→dividend reg and y→divisor reg.
    - If y==0, go to ZERO.
    - Otherwise go to RUN with counter=W.
  - RUN: ready=0. Each posedge performs one restoring step:
    - diff = {rem[W-1:0], dq[W-1]} − {1'b0, div}, at W+1 bits.
    - If diff[W]=1: {rem,dq} shifts left, inserting quotient bit 0.
    - Else: rem=diff[W-1:0], dq shifts left, inserting quotient bit 1.
    - counter decrements. On the step where counter==1, the final q/r are written to the outputs, done=1 on that same edge, and the state returns to IDLE (ready=1).
  - ZERO: one cycle. Next posedge: q=all ones, r=x (latched dividend), dbz=1, done=1, back to IDLE.
- Latency: accepting edge E0. For y≠0, done is high in the cycle after edge E_W. For y==0, done is high after E1.
- Throughput: a new load may be accepted on the edge where done is asserted is NOT allowed: ready is low until that edge. The earliest next accept is the edge after done rises, so issue is back-to-back with zero gap cycles.
- load while ready=0 is ignored, with no queuing. x/y changes during RUN have no effect.
- dbz is cleared to 0 on every non-zero-divisor done.
- done is high for exactly one cycle per accepted load.
- Unsigned identity: x == q*y + r with r < y, whenever dbz=0.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined: when sgn=1 at accept, operands are treated as two's complement.
  - Division runs on magnitudes.
  - q is negated if the sign bits of x and y differ. r takes the sign of x (truncating division).
  - Sign correction happens on the done edge, so latency is unchanged.
  - x = most-negative, y = −1 gives q = most-negative (wraps) and r = 0, with no flag.
  - Signed divide-by-zero gives q = all ones and r = x.
- Undefined: the sgn port still exists but is ignored. All divisions are unsigned.

Test Plan:
- W=16, unsigned: x=100, y=7, load for 1 cycle → ready drops next cycle; done after 16 edges with q=14, r=2, dbz=0; ready=1 during done.
- W=16: x=1234, y=0 → done after edge E1 with q=16'hFFFF, r=1234, dbz=1. Next op x=9, y=3 → q=3, r=0, dbz=0.
- W=16: x=5, y=9 → q=0, r=5. Then x=16'hFFFF, y=1 → q=16'hFFFF, r=0. Assert load mid-RUN with other operands → ignored, results unchanged.
- Reset mid-op: x=100, y=7 accepted, rst=1 at E5 → no done pulse; q=0, r=0, ready=1 after the reset edge; a fresh op then completes correctly.
- SIGNED_DIV_EN, sgn=1, W=16: x=−7 (16'hFFF9), y=2 → q=−3 (16'hFFFD), r=−1 (16'hFFFF). x=16'h8000, y=16'hFFFF → q=16'h8000, r=0.
- Randomised soak, W=8 and W=16: 1000 back-to-back ops checked against the reference model x==q*y+r, plus done-count equal to accept-count.
